// File: rtl/clmul_iter_if.sv
// Handshake bundle for the iterative carry-less multiplier: operand side,
// result side and the pipeline flush, grouped so that producer and consumer
// can be wired with a single port.
interface clmul_iter_if #(
   parameter int WIDTH = 32
);
   logic             Flush;
   logic             InValid;
   logic             InReady;
   logic [WIDTH-1:0] X;
   logic [WIDTH-1:0] Y;
   logic [1:0]       Mode;
   logic             OutValid;
   logic             OutReady;
   logic [WIDTH-1:0] ClmulResult;

   // The pipeline side that presents operands and consumes results
   modport master (
      output Flush, InValid, X, Y, Mode, OutReady,
      input  InReady, OutValid, ClmulResult
   );

   // The multiplier itself
   modport slave (
      input  Flush, InValid, X, Y, Mode, OutReady,
      output InReady, OutValid, ClmulResult
   );
endinterface

// File: rtl/clmul_iter.sv
// Iterative carry-less multiplier for the Zbc path (clmul / clmulh / clmulr).
// Consumes STEP bits of Y per cycle; after WIDTH/STEP busy cycles the selected
// half (or the clmulr window) of the double-width product is registered and
// held until the consumer takes it. Flush aborts anything in flight.
module clmul_iter #(
   parameter int WIDTH = 32,
   parameter int STEP  = 1
) (
   input  logic         clk,
   input  logic         reset,
   clmul_iter_if.slave  bus
);

   localparam int N     = WIDTH / STEP;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   // A STEP that does not divide WIDTH would leave a ragged last iteration
   if (WIDTH % STEP != 0) begin : gBadStep
      $error("clmul_iter: STEP must divide WIDTH");
   end

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } StateT;

   StateT              r_state;
   StateT              w_nextState;
   logic [2*WIDTH-1:0] r_xShift;
   logic [WIDTH-1:0]   r_y;
   logic [1:0]         r_mode;
   logic [2*WIDTH-1:0] r_prod;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_result;

   logic               w_inReady;
   logic               w_accept;
   logic               w_lastStep;
   logic [2*WIDTH-1:0] w_partial;
   logic [2*WIDTH-1:0] w_prodNext;
   logic [WIDTH-1:0]   w_select;

   assign w_inReady  = (r_state == IDLE) || ((r_state == DONE) && bus.OutReady);
   assign w_accept   = bus.InValid && w_inReady && !bus.Flush;
   assign w_lastStep = (r_cnt == CNT_W'(N - 1));
   assign w_prodNext = r_prod ^ w_partial;

   assign bus.InReady     = w_inReady;
   assign bus.OutValid    = (r_state == DONE);
   assign bus.ClmulResult = r_result;

   // Partial product for this iteration; X is kept pre-shifted by cnt*STEP,
   // so only the in-step offset k has to be applied here
   always_comb begin
      w_partial = '0;
      for (int k = 0; k < STEP; k++) begin
         if (r_y[k]) begin
            w_partial = w_partial ^ (r_xShift << k);
         end
      end
   end

   // Pick the requested slice of the product that will exist after this cycle;
   // the reserved mode falls back to plain clmul
   always_comb begin
      w_select = w_prodNext[WIDTH-1:0];
      case (r_mode)
         2'b01:   w_select = w_prodNext[2*WIDTH-1:WIDTH];
         2'b10:   w_select = w_prodNext[2*WIDTH-2:WIDTH-1];
         default: w_select = w_prodNext[WIDTH-1:0];
      endcase
   end

   // State register; reset drops straight back to IDLE with no output pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state: fixed N busy cycles, hold in DONE until taken, flush wins
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_nextState = BUSY;
            end
         end
         BUSY: begin
            if (w_lastStep) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            if (bus.OutReady) begin
               w_nextState = w_accept ? BUSY : IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
      if (bus.Flush) begin
         w_nextState = IDLE;
      end
   end

   // Operand capture on accept, then shift-and-accumulate while busy; the
   // result register is loaded only on the final busy cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_xShift <= '0;
         r_y      <= '0;
         r_mode   <= '0;
         r_prod   <= '0;
         r_cnt    <= '0;
         r_result <= '0;
      end else if (w_accept) begin
         r_xShift <= {{WIDTH{1'b0}}, bus.X};
         r_y      <= bus.Y;
         r_mode   <= bus.Mode;
         r_prod   <= '0;
         r_cnt    <= '0;
      end else if ((r_state == BUSY) && !bus.Flush) begin
         r_prod   <= w_prodNext;
         r_xShift <= r_xShift << STEP;
         r_y      <= r_y >> STEP;
         r_cnt    <= r_cnt + CNT_W'(1);
         if (w_lastStep) begin
            r_result <= w_select;
         end
      end
   end

endmodule

// File: tb/tb_clmul_iter.sv
// Bench for clmul_iter: a STEP=1 and a STEP=4 instance (both 32 bit) share
// clock and reset. Accepted operations push a model result into a per-DUT
// queue; each output handshake pops and compares it.
module tb_clmul_iter;

   logic clk;
   logic reset;

   int checkCount;
   int failCount;

   clmul_iter_if #(.WIDTH(32)) busA ();
   clmul_iter_if #(.WIDTH(32)) busB ();

   clmul_iter #(.WIDTH(32), .STEP(1)) dutA (
      .clk   (clk),
      .reset (reset),
      .bus   (busA.slave)
   );

   clmul_iter #(.WIDTH(32), .STEP(4)) dutB (
      .clk   (clk),
      .reset (reset),
      .bus   (busB.slave)
   );

   logic [31:0] qA[$];
   logic [31:0] qB[$];
   bit          randReadyB;

   // 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Every comparison in the bench funnels through here
   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
      end
   endtask

   // Reference: plain XOR-shift product, then pick the requested slice
   function automatic logic [31:0] clmulRef(input logic [31:0] x, input logic [31:0] y, input logic [1:0] m);
      logic [63:0] p;
      p = '0;
      for (int i = 0; i < 32; i++) begin
         if (y[i]) p = p ^ ({32'b0, x} << i);
      end
      case (m)
         2'b01:   return p[63:32];
         2'b10:   return p[62:31];
         default: return p[31:0];
      endcase
   endfunction

   function automatic logic getInReady(input int sel);
      return (sel == 0) ? busA.InReady : busB.InReady;
   endfunction

   function automatic logic getOutValid(input int sel);
      return (sel == 0) ? busA.OutValid : busB.OutValid;
   endfunction

   function automatic logic [31:0] getResult(input int sel);
      return (sel == 0) ? busA.ClmulResult : busB.ClmulResult;
   endfunction

   // Scoreboard for A: pop on output handshake, push on accept, drop on flush
   always @(negedge clk) begin
      if (!reset) begin
         if (busA.Flush) begin
            qA.delete();
         end else begin
            if (busA.OutValid && busA.OutReady) begin
               checkOutput("A pending", (qA.size() > 0), 1);
               if (qA.size() > 0) checkOutput("A result", busA.ClmulResult, qA.pop_front());
            end
            if (busA.InValid && busA.InReady) qA.push_back(clmulRef(busA.X, busA.Y, busA.Mode));
         end
      end
   end

   // Scoreboard for B, same rules
   always @(negedge clk) begin
      if (!reset) begin
         if (busB.Flush) begin
            qB.delete();
         end else begin
            if (busB.OutValid && busB.OutReady) begin
               checkOutput("B pending", (qB.size() > 0), 1);
               if (qB.size() > 0) checkOutput("B result", busB.ClmulResult, qB.pop_front());
            end
            if (busB.InValid && busB.InReady) qB.push_back(clmulRef(busB.X, busB.Y, busB.Mode));
         end
      end
   end

   // Random consumer back-pressure on B while enabled
   always @(posedge clk) begin
      if (randReadyB) begin
         #1;
         busB.OutReady = 1'($urandom_range(0, 1));
      end
   end

   // Present one operation, wait for acceptance, optionally wait for the result.
   // lat counts clock edges from the accepting edge to OutValid visible.
   task automatic applyStimulus(input int sel, input logic [31:0] x, input logic [31:0] y,
                                input logic [1:0] m, input bit waitDone,
                                output int lat, output logic [31:0] res, output int stall);
      int guard;
      lat   = 0;
      res   = '0;
      stall = 0;
      guard = 0;
      if (sel == 0) begin
         busA.InValid = 1'b1; busA.X = x; busA.Y = y; busA.Mode = m;
      end else begin
         busB.InValid = 1'b1; busB.X = x; busB.Y = y; busB.Mode = m;
      end
      @(negedge clk);
      while (!getInReady(sel) && guard < 200) begin
         stall++;
         guard++;
         @(negedge clk);
      end
      checkOutput("accept in time", 64'(guard < 200), 1);
      @(posedge clk);
      #1;
      if (sel == 0) begin
         busA.InValid = 1'b0; busA.X = $urandom; busA.Y = $urandom; busA.Mode = 2'($urandom);
      end else begin
         busB.InValid = 1'b0; busB.X = $urandom; busB.Y = $urandom; busB.Mode = 2'($urandom);
      end
      if (waitDone) begin
         lat = 1;
         while (!getOutValid(sel) && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
         end
         res = getResult(sel);
      end
   endtask

   // Bound on total run time in case the DUT stalls forever
   initial begin
      #800000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int          lat;
      int          stall;
      int          seen;
      int          guard;
      logic [31:0] res;
      logic [31:0] held;

      checkCount = 0;
      failCount  = 0;
      randReadyB = 1'b0;
      busA.Flush = 1'b0; busA.InValid = 1'b0; busA.OutReady = 1'b1;
      busA.X = '0; busA.Y = '0; busA.Mode = '0;
      busB.Flush = 1'b0; busB.InValid = 1'b0; busB.OutReady = 1'b1;
      busB.X = '0; busB.Y = '0; busB.Mode = '0;
      reset = 1'b1;
      #12;
      checkOutput("reset A OutValid", busA.OutValid, 0);
      checkOutput("reset A InReady", busA.InReady, 1);
      checkOutput("reset A result", busA.ClmulResult, 0);
      checkOutput("reset B OutValid", busB.OutValid, 0);
      checkOutput("reset B InReady", busB.InReady, 1);
      @(posedge clk);
      #1;
      reset = 1'b0;

      $display("[TB] directed vectors, STEP=1 and STEP=4");
      applyStimulus(0, 32'h80000001, 32'h3, 2'b00, 1, lat, res, stall);
      checkOutput("A clmul latency", lat, 33);
      checkOutput("A clmul 8..1*3", res, 32'h80000003);
      applyStimulus(0, 32'h80000001, 32'h3, 2'b01, 1, lat, res, stall);
      checkOutput("A clmulh 8..1*3", res, 32'h00000001);
      applyStimulus(0, 32'h80000001, 32'h3, 2'b10, 1, lat, res, stall);
      checkOutput("A clmulr 8..1*3", res, 32'h00000003);
      applyStimulus(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 1, lat, res, stall);
      checkOutput("A clmul ones", res, 32'h55555555);
      applyStimulus(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 1, lat, res, stall);
      checkOutput("A clmulh ones", res, 32'h55555555);
      applyStimulus(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 1, lat, res, stall);
      checkOutput("A clmulr ones", res, 32'hAAAAAAAA);
      applyStimulus(0, 32'h80000001, 32'h3, 2'b11, 1, lat, res, stall);
      checkOutput("A reserved mode", res, 32'h80000003);
      applyStimulus(0, 32'hDEADBEEF, 32'h0, 2'b01, 1, lat, res, stall);
      checkOutput("A Y=0 latency", lat, 33);
      checkOutput("A Y=0 result", res, 32'h0);
      applyStimulus(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 1, lat, res, stall);
      checkOutput("B clmul latency", lat, 9);
      checkOutput("B clmul ones", res, 32'h55555555);
      applyStimulus(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 1, lat, res, stall);
      checkOutput("B clmulh ones", res, 32'h55555555);
      applyStimulus(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 1, lat, res, stall);
      checkOutput("B clmulr ones", res, 32'hAAAAAAAA);
      applyStimulus(1, 32'h80000001, 32'h3, 2'b10, 1, lat, res, stall);
      checkOutput("B clmulr 8..1*3", res, 32'h00000003);

      $display("[TB] output stall then back-to-back accept");
      @(posedge clk);
      #1;
      busA.OutReady = 1'b0;
      applyStimulus(0, 32'h12345678, 32'h9ABCDEF1, 2'b01, 1, lat, res, stall);
      checkOutput("stall latency", lat, 33);
      held = res;
      checkOutput("stall first result", held, clmulRef(32'h12345678, 32'h9ABCDEF1, 2'b01));
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         checkOutput("stall OutValid", busA.OutValid, 1);
         checkOutput("stall InReady", busA.InReady, 0);
         checkOutput("stall result", busA.ClmulResult, held);
      end
      busA.OutReady = 1'b1;
      applyStimulus(0, 32'h0F0F0F0F, 32'h00FF00FF, 2'b10, 1, lat, res, stall);
      checkOutput("b2b accept wait", stall, 0);
      checkOutput("b2b latency", lat, 33);
      checkOutput("b2b result", res, clmulRef(32'h0F0F0F0F, 32'h00FF00FF, 2'b10));

      $display("[TB] flush handling");
      applyStimulus(0, 32'hCAFEBABE, 32'h76543210, 2'b00, 0, lat, res, stall);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      busA.Flush = 1'b1;
      @(posedge clk);
      #1;
      busA.Flush = 1'b0;
      checkOutput("flush OutValid", busA.OutValid, 0);
      checkOutput("flush to IDLE", busA.InReady, 1);
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (busA.OutValid) seen++;
      end
      checkOutput("flush no OutValid", seen, 0);
      busA.Flush = 1'b1; busA.InValid = 1'b1; busA.X = 32'h1; busA.Y = 32'h1;
      @(posedge clk);
      #1;
      busA.Flush = 1'b0; busA.InValid = 1'b0;
      checkOutput("flush+InValid idle", busA.InReady, 1);
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (busA.OutValid) seen++;
      end
      checkOutput("flush+InValid no op", seen, 0);

      $display("[TB] reset mid-operation");
      applyStimulus(0, 32'hA5A5A5A5, 32'h5A5A5A5A, 2'b01, 0, lat, res, stall);
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async reset OutValid", busA.OutValid, 0);
      checkOutput("async reset InReady", busA.InReady, 1);
      checkOutput("async reset result", busA.ClmulResult, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      qA.delete();
      qB.delete();
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (busA.OutValid) seen++;
      end
      checkOutput("reset no OutValid", seen, 0);
      applyStimulus(0, 32'h80000001, 32'h3, 2'b01, 1, lat, res, stall);
      checkOutput("post-reset latency", lat, 33);
      checkOutput("post-reset result", res, 32'h00000001);

      $display("[TB] random back-to-back operations");
      for (int i = 0; i < 300; i++) begin
         applyStimulus(0, $urandom, $urandom, 2'($urandom_range(0, 3)), 0, lat, res, stall);
      end
      randReadyB = 1'b1;
      for (int i = 0; i < 400; i++) begin
         applyStimulus(1, $urandom, $urandom, 2'($urandom_range(0, 3)), 0, lat, res, stall);
      end
      randReadyB = 1'b0;
      @(posedge clk);
      #2;
      busB.OutReady = 1'b1;
      guard = 0;
      while ((qA.size() != 0 || qB.size() != 0) && guard < 200) begin
         @(posedge clk);
         #1;
         guard++;
      end
      checkOutput("A drained", qA.size(), 0);
      checkOutput("B drained", qB.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
